// File: rtl/srdl2sv_if_pkg.sv
// Register-side request/response types shared by bus bridges, the arbiter and the register block.
package srdl2sv_if_pkg;
    typedef struct packed {
        logic        w_vld;
        logic        r_vld;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  byte_en;
    } b2r_t;

    typedef struct packed {
        logic        rdy;
        logic        err;
        logic [31:0] data;
    } r2b_t;
endpackage

// File: rtl/srdl2sv_b2r_arbiter_if.sv
// Requester-side and register-side signals of the b2r arbiter; master is the arbiter, slave the environment.
interface srdl2sv_b2r_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]    req_w_vld;
    logic [N_REQ-1:0]    req_r_vld;
    logic [N_REQ*32-1:0] req_addr;
    logic [N_REQ*32-1:0] req_data;
    logic [N_REQ*4-1:0]  req_byte_en;
    logic [N_REQ-1:0]    req_rdy;
    logic                req_err;
    logic [31:0]         req_rdata;
    srdl2sv_if_pkg::b2r_t b2r;
    srdl2sv_if_pkg::r2b_t r2b;
    logic [N_REQ-1:0]    grant;

    modport master (
        input  req_w_vld, req_r_vld, req_addr, req_data, req_byte_en, r2b,
        output req_rdy, req_err, req_rdata, b2r, grant
    );

    modport slave (
        output req_w_vld, req_r_vld, req_addr, req_data, req_byte_en, r2b,
        input  req_rdy, req_err, req_rdata, b2r, grant
    );
endinterface

// File: rtl/srdl2sv_b2r_arbiter.sv
// Round-robin arbiter sharing one b2r/r2b register port between N_REQ bridges,
// with a registered grant and a per-transaction watchdog that forces an error response.
module srdl2sv_b2r_arbiter #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 64,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    srdl2sv_b2r_arbiter_if.master bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    arb_state_t           state, state_nxt;
    logic [N_REQ-1:0]     grant, grant_nxt;
    logic [N_REQ-1:0]     active, others;
    logic [PTR_W-1:0]     last_ptr, last_ptr_nxt, gidx;
    logic [TO_W-1:0]      wdog, wdog_nxt;
    srdl2sv_if_pkg::b2r_t sel;
    logic                 sel_act;

    // First set bit of mask searching last+1, last+2, ... modulo N_REQ
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] mask,
                                                 input logic [PTR_W-1:0] last);
        logic [N_REQ-1:0] oh;
        int               idx;
        oh = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (oh == '0 && mask[idx]) oh[idx] = 1'b1;
        end
        return oh;
    endfunction

    assign active    = bus.req_w_vld | bus.req_r_vld;
    assign others    = active & ~grant;
    assign bus.grant = grant;
    assign sel_act   = sel.w_vld | sel.r_vld;

    always_comb begin
        sel  = '0;
        gidx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel.w_vld   = bus.req_w_vld[i];
                sel.r_vld   = bus.req_r_vld[i];
                sel.addr    = bus.req_addr[32*i +: 32];
                sel.data    = bus.req_data[32*i +: 32];
                sel.byte_en = bus.req_byte_en[4*i +: 4];
                gidx        = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        last_ptr_nxt  = last_ptr;
        wdog_nxt      = wdog;
        bus.b2r       = '0;
        bus.req_rdy   = '0;
        bus.req_err   = 1'b0;
        bus.req_rdata = '0;
        case (state)
            ARB_IDLE: begin
                if (|active) begin
                    grant_nxt = rr_pick(active, last_ptr);
                    wdog_nxt  = '0;
                    state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!sel_act) begin
                    // Owner withdrew mid-transaction: abandon it without a response
                    grant_nxt = '0;
                    wdog_nxt  = '0;
                    state_nxt = ARB_IDLE;
                end else if (bus.r2b.rdy) begin
                    bus.b2r       = sel;
                    bus.req_rdy   = grant;
                    bus.req_err   = bus.r2b.err;
                    bus.req_rdata = bus.r2b.data;
                    last_ptr_nxt  = gidx;
                    wdog_nxt      = '0;
                    if (|others) begin
                        grant_nxt = rr_pick(others, gidx);
                    end else begin
                        grant_nxt = '0;
                        state_nxt = ARB_IDLE;
                    end
                end else if (wdog == TO_W'(TIMEOUT - 1)) begin
                    bus.req_rdy  = grant;
                    bus.req_err  = 1'b1;
                    last_ptr_nxt = gidx;
                    wdog_nxt     = '0;
                    grant_nxt    = '0;
                    state_nxt    = ARB_IDLE;
                end else begin
                    bus.b2r  = sel;
                    wdog_nxt = wdog + TO_W'(1);
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            last_ptr <= PTR_W'(N_REQ - 1);
            wdog     <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            last_ptr <= last_ptr_nxt;
            wdog     <= wdog_nxt;
        end
    end
endmodule

// File: doc/srdl2sv_b2r_arbiter.md
Name: srdl2sv_b2r_arbiter

Overview:
- Shares one register-side interface (b2r/r2b, srdl2sv_if_pkg) between N_REQ bus bridges, e.g. an AHB-Lite bridge and a debug bridge.
- Round-robin arbiter with registered grant and a per-transaction watchdog.
- The granted requester's request is forwarded to the register block; the register block's response is returned only to that requester.
- Sits between the bus widgets and the generated register block.

Parameters:
- N_REQ, 2: number of requesters (2..8).
- TIMEOUT, 64: cycles a granted transaction may wait for rdy before a forced error response (>=2).
- TO_W, $clog2(TIMEOUT+1): watchdog counter width (derived; do not override).

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- req_w_vld  in  N_REQ  per-requester write valid
- req_r_vld  in  N_REQ  per-requester read valid
- req_addr  in  N_REQ*32  per-requester address, packed, requester i at [32i+:32]
- req_data  in  N_REQ*32  per-requester write data
- req_byte_en  in  N_REQ*4  per-requester byte enables
- req_rdy  out  N_REQ  per-requester completion strobe
- req_err  out  1  error qualifier, valid with any req_rdy bit
- req_rdata  out  32  read data, valid with any req_rdy bit
- b2r  out  b2r_t  to register block (w_vld, r_vld, addr, data, byte_en)
- r2b  in  r2b_t  from register block (rdy, err, data)
- grant  out  N_REQ  one-hot current owner; all-zero when idle

Behaviour:
- A requester is active when w_vld|r_vld. It holds addr, data, byte_en and vld stable until its req_rdy bit pulses. w_vld and r_vld are never both high.
- Reset values: grant=0, b2r.w_vld=0, b2r.r_vld=0, req_rdy=0, req_err=0, watchdog=0, last_ptr=N_REQ-1 (requester 0 wins first), state ARB_IDLE.
- Reset mid-transaction drops the grant immediately; no response is issued.
- ARB_IDLE:
  - With any requester active, pick the first active index searching last_ptr+1, last_ptr+2, ... modulo N_REQ.
  - Register the one-hot grant; go to ARB_BUSY.
  - b2r valids are 0 in this state.
  - Arbitration latency is 1 cycle: request at cycle t gives b2r valid at t+1.
- ARB_BUSY:
  - b2r is a combinational mux of the granted requester's signals.
  - req_rdy[g]=r2b.rdy, req_err=r2b.err, req_rdata=r2b.data; all other req_rdy bits are 0.
  - Watchdog increments each BUSY cycle.
- Completion (r2b.rdy=1 in BUSY):
  - last_ptr<=g; watchdog<=0.
  - If another requester (mask g) is active, regrant directly (back-to-back, no idle cycle) and stay in BUSY. Otherwise go to ARB_IDLE.
  - g is masked this cycle only. If g raises a new request next cycle, it competes normally.
- Timeout (watchdog reaches TIMEOUT-1 without r2b.rdy):
  - That cycle: req_rdy[g]=1, req_err=1, req_rdata=0, b2r valids forced to 0.
  - last_ptr<=g; go to ARB_IDLE.
  - A late r2b.rdy in a following cycle is ignored.
- Requester drops vld while granted (protocol violation):
  - Abort: b2r valids 0 that cycle, no req_rdy, go to ARB_IDLE, last_ptr unchanged.
- Simultaneous r2b.rdy and timeout cycle: normal completion wins; r2b.err is passed through.
- grant is always one-hot or zero. b2r valid is never high in ARB_IDLE.
- Single requester N_REQ=1: degenerates to a 1-cycle registered pass-through with watchdog.

Test Plan:
- Reset, then requester 0 reads addr 0x10, r2b.rdy at first BUSY cycle with data 0xCAFE0001 -> grant=01 at t+1, req_rdy=01, req_rdata=0xCAFE0001, req_err=0, back to IDLE at t+2.
- Both requesters write continuously, register block always ready -> grants alternate 01,10,01,10 with no idle cycles between completions; each b2r.addr matches its owner.
- Requester 1 granted, r2b.rdy held low, TIMEOUT=64 -> at the 64th BUSY cycle req_rdy=10, req_err=1, b2r valids 0; next cycle IDLE; a later r2b.rdy produces no req_rdy.
- r2b.err=1 with r2b.rdy on write from requester 0 -> req_rdy=01, req_err=1, arbitration continues normally.
- HRESETn asserted mid-BUSY with requester 1 granted -> grant=0, b2r valids 0 asynchronously; after release requester 0 wins first if both are active.
- Requester 0 drops w_vld while granted -> no req_rdy, IDLE next cycle, last_ptr unchanged so requester 0 retains priority.
